// File: rtl/neuron_layer_stream.sv
// Neuron value register bank: addressed overwrite / saturating-accumulate loads, streamed out with optional ReLU.
// Latency: loads visible on values one cycle after the load edge; first beat valid the cycle after stream_start.
// Backpressure: out_ready low holds out_valid/out_index/out_data; loads are rejected while streaming.
module neuron_layer_stream #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_NEURONS = 2,
   parameter int ADDR_WIDTH  = 16,
   parameter int RELU_EN     = 1,
   localparam int IW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear,
   input  logic                              load_en,
   input  logic                              load_mode,
   input  logic [ADDR_WIDTH-1:0]             load_address,
   input  logic [DATA_WIDTH-1:0]             load_value,
   output logic                              load_reject,
   output logic [NUM_NEURONS*DATA_WIDTH-1:0] values,
   input  logic                              stream_start,
   output logic                              busy,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH-1:0]             out_data,
   output logic [IW-1:0]                     out_index,
   output logic                              out_last,
   output logic                              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t                        state;
   state_t                        state_nxt;
   logic signed [DATA_WIDTH-1:0]  regs [NUM_NEURONS];
   logic                          addr_in_range;
   logic                          load_ok;
   logic [NUM_NEURONS-1:0]        hit;
   logic                          xfer;
   logic [DATA_WIDTH-1:0]         cur;

   // Add at DATA_WIDTH+1 bits; a disagreement between the top two sum bits means overflow,
   // and the top bit then tells which rail to clamp to.
   function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] s;
      s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
         return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
      return s[DATA_WIDTH-1:0];
   endfunction

   // Load qualification: clear wins, and the bank is frozen outside IDLE so streamed data is stable.
   always_comb begin
      addr_in_range = {1'b0, load_address} < (ADDR_WIDTH+1)'(NUM_NEURONS);
      load_ok       = load_en && !clear && (state == S_IDLE) && addr_in_range;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         hit[i] = load_ok && ({1'b0, load_address} == (ADDR_WIDTH+1)'(i));
      end
   end

   // Neuron register bank: clear > load > hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_NEURONS; i++) regs[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_NEURONS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (hit[i]) regs[i] <= load_mode ? sat_add(regs[i], load_value) : load_value;
         end
      end
   end

   // Reject pulse is registered so it lines up with the cycle the load would have become visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) load_reject <= 1'b0;
      else        load_reject <= load_en && !clear && !load_ok;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE: begin
            if (stream_start) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && out_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign xfer     = out_valid && out_ready;
   assign out_last = out_valid && (out_index == IW'(NUM_NEURONS - 1));

   // Beat index: advances on each transfer and rewinds to 0 on the final one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_index <= '0;
      end else if (xfer) begin
         out_index <= out_last ? '0 : out_index + IW'(1);
      end
   end

   // Combinational read of the current beat, optionally rectified.
   always_comb begin
      cur      = regs[out_index];
      out_data = cur;
      if ((RELU_EN != 0) && cur[DATA_WIDTH-1]) out_data = '0;
   end

   // Flatten the bank onto the raw values bus, neuron i in slice i.
   always_comb begin
      values = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         values[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
      end
   end

endmodule

// File: tb/tb_neuron_layer_stream.sv
module tb_neuron_layer_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;

   // Two-neuron instance with ReLU
   logic        a_clear, a_load_en, a_load_mode, a_load_reject;
   logic [15:0] a_load_address, a_load_value;
   logic [31:0] a_values;
   logic        a_stream_start, a_busy, a_out_valid, a_out_ready, a_out_last, a_done;
   logic [15:0] a_out_data;
   logic [0:0]  a_out_index;

   // Four-neuron instance, raw output
   logic        b_clear, b_load_en, b_load_mode, b_load_reject;
   logic [15:0] b_load_address, b_load_value;
   logic [63:0] b_values;
   logic        b_stream_start, b_busy, b_out_valid, b_out_ready, b_out_last, b_done;
   logic [15:0] b_out_data;
   logic [1:0]  b_out_index;

   neuron_layer_stream #(.DATA_WIDTH(16), .NUM_NEURONS(2), .ADDR_WIDTH(16), .RELU_EN(1)) dut_a (
      .clk(clk), .reset(reset), .clear(a_clear), .load_en(a_load_en), .load_mode(a_load_mode),
      .load_address(a_load_address), .load_value(a_load_value), .load_reject(a_load_reject),
      .values(a_values), .stream_start(a_stream_start), .busy(a_busy), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .out_index(a_out_index),
      .out_last(a_out_last), .done(a_done));

   neuron_layer_stream #(.DATA_WIDTH(16), .NUM_NEURONS(4), .ADDR_WIDTH(16), .RELU_EN(0)) dut_b (
      .clk(clk), .reset(reset), .clear(b_clear), .load_en(b_load_en), .load_mode(b_load_mode),
      .load_address(b_load_address), .load_value(b_load_value), .load_reject(b_load_reject),
      .values(b_values), .stream_start(b_stream_start), .busy(b_busy), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_index(b_out_index),
      .out_last(b_out_last), .done(b_done));

   int checks = 0;
   int errors = 0;

   // Reference model: neuron values as plain signed integers
   int ma [2];
   int mb [4];

   function automatic int sat(input int s);
      if (s > 32767)  return 32767;
      if (s < -32768) return -32768;
      return s;
   endfunction

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic logic [15:0] relu16(input int v);
      return (v < 0) ? 16'h0000 : 16'(v);
   endfunction

   function automatic logic [31:0] pack_a();
      logic [31:0] p;
      for (int i = 0; i < 2; i++) p[i*16 +: 16] = 16'(ma[i]);
      return p;
   endfunction

   function automatic logic [63:0] pack_b();
      logic [63:0] p;
      for (int i = 0; i < 4; i++) p[i*16 +: 16] = 16'(mb[i]);
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_load(input logic mode, input int addr, input logic [15:0] val);
      a_load_en      = 1'b1;
      a_load_mode    = mode;
      a_load_address = addr[15:0];
      a_load_value   = val;
      tick();
      a_load_en      = 1'b0;
   endtask

   task automatic b_load(input logic mode, input int addr, input logic [15:0] val);
      b_load_en      = 1'b1;
      b_load_mode    = mode;
      b_load_address = addr[15:0];
      b_load_value   = val;
      tick();
      b_load_en      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) tick();
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_a_done: got %b want 0", a_done); end
      checks++; if (a_load_reject !== 1'b0) begin errors++; $display("FAIL reset_a_reject: got %b want 0", a_load_reject); end
      checks++; if (a_out_index !== 1'b0) begin errors++; $display("FAIL reset_a_index: got %h want 0", a_out_index); end
      checks++; if (a_values !== 32'h0) begin errors++; $display("FAIL reset_a_values: got %h want 0", a_values); end
      checks++; if (b_values !== 64'h0) begin errors++; $display("FAIL reset_b_values: got %h want 0", b_values); end
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_out_valid); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_overwrite();
      int addr;
      logic [15:0] v;
      a_load(1'b0, 0, 16'h0005); ma[0] = 5;
      checks++; if (a_load_reject !== 1'b0) begin errors++; $display("FAIL ow_reject0: got %b want 0", a_load_reject); end
      a_load(1'b0, 1, 16'hFFF0); ma[1] = -16;
      checks++; if (a_values !== 32'hFFF0_0005) begin errors++; $display("FAIL ow_values: got %h want fff00005", a_values); end
      checks++; if (a_load_reject !== 1'b0) begin errors++; $display("FAIL ow_reject1: got %b want 0", a_load_reject); end
      for (int k = 0; k < 6; k++) begin
         addr = $urandom_range(0, 1);
         v    = 16'($urandom);
         a_load(1'b0, addr, v);
         ma[addr] = sx(v);
         checks++; if (a_values !== pack_a()) begin errors++; $display("FAIL ow_rand: got %h want %h", a_values, pack_a()); end
      end
   endtask

   task automatic test_accumulate();
      int addr;
      logic mode;
      logic [15:0] v;
      a_load(1'b0, 0, 16'h7FF0);
      a_load(1'b1, 0, 16'h0020); ma[0] = 32767;
      checks++; if (a_values[15:0] !== 16'h7FFF) begin errors++; $display("FAIL acc_pos_sat: got %h want 7fff", a_values[15:0]); end
      a_load(1'b0, 1, 16'h8010);
      a_load(1'b1, 1, 16'hFFE0); ma[1] = -32768;
      checks++; if (a_values[31:16] !== 16'h8000) begin errors++; $display("FAIL acc_neg_sat: got %h want 8000", a_values[31:16]); end
      for (int k = 0; k < 16; k++) begin
         addr = $urandom_range(0, 1);
         mode = ($urandom_range(0, 3) != 0);
         v    = 16'($urandom);
         a_load(mode, addr, v);
         ma[addr] = mode ? sat(ma[addr] + sx(v)) : sx(v);
         checks++; if (a_values !== pack_a()) begin errors++; $display("FAIL acc_rand: got %h want %h", a_values, pack_a()); end
      end
   endtask

   task automatic test_reject_clear();
      a_load(1'b0, 2, 16'h1234);
      checks++; if (a_load_reject !== 1'b1) begin errors++; $display("FAIL rej_pulse: got %b want 1", a_load_reject); end
      checks++; if (a_values !== pack_a()) begin errors++; $display("FAIL rej_unchanged: got %h want %h", a_values, pack_a()); end
      tick();
      checks++; if (a_load_reject !== 1'b0) begin errors++; $display("FAIL rej_one_cycle: got %b want 0", a_load_reject); end
      for (int k = 0; k < 4; k++) begin
         a_load(1'($urandom_range(0, 1)), $urandom_range(2, 65535), 16'($urandom));
         checks++; if (a_load_reject !== 1'b1 || a_values !== pack_a()) begin
            errors++; $display("FAIL rej_rand: reject %b values %h want 1 %h", a_load_reject, a_values, pack_a());
         end
      end
      a_clear = 1'b1;
      a_load(1'b0, 0, 16'h4321);
      a_clear = 1'b0;
      ma[0] = 0; ma[1] = 0;
      checks++; if (a_values !== 32'h0) begin errors++; $display("FAIL clear_load_values: got %h want 0", a_values); end
      checks++; if (a_load_reject !== 1'b0) begin errors++; $display("FAIL clear_load_reject: got %b want 0", a_load_reject); end
   endtask

   task automatic test_stream_relu();
      a_load(1'b0, 0, 16'h0005); ma[0] = 5;
      a_load(1'b0, 1, 16'hFFF0); ma[1] = -16;
      a_out_ready    = 1'b1;
      a_stream_start = 1'b1;
      tick();
      a_stream_start = 1'b0;
      checks++; if (a_out_valid !== 1'b1 || a_out_index !== 1'b0 || a_out_data !== relu16(ma[0]) || a_out_last !== 1'b0) begin
         errors++; $display("FAIL relu_beat0: v%b i%h d%h l%b want 1 0 %h 0", a_out_valid, a_out_index, a_out_data, a_out_last, relu16(ma[0]));
      end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL relu_busy: got %b want 1", a_busy); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_index !== 1'b1 || a_out_data !== relu16(ma[1]) || a_out_last !== 1'b1) begin
         errors++; $display("FAIL relu_beat1: v%b i%h d%h l%b want 1 1 %h 1", a_out_valid, a_out_index, a_out_data, a_out_last, relu16(ma[1]));
      end
      tick();
      checks++; if (a_out_valid !== 1'b0 || a_done !== 1'b1 || a_busy !== 1'b1) begin
         errors++; $display("FAIL relu_done: v%b done%b busy%b want 0 1 1", a_out_valid, a_done, a_busy);
      end
      tick();
      checks++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_out_index !== 1'b0) begin
         errors++; $display("FAIL relu_idle: done%b busy%b i%h want 0 0 0", a_done, a_busy, a_out_index);
      end
      a_out_ready = 1'b0;
   endtask

   task automatic test_clear_stream();
      a_load(1'b0, 0, 16'h0007); ma[0] = 7;
      a_load(1'b0, 1, 16'h0009); ma[1] = 9;
      a_out_ready    = 1'b1;
      a_stream_start = 1'b1;
      tick();
      a_stream_start = 1'b0;
      checks++; if (a_out_data !== relu16(ma[0]) || a_out_index !== 1'b0) begin
         errors++; $display("FAIL clrs_beat0: d%h i%h want %h 0", a_out_data, a_out_index, relu16(ma[0]));
      end
      a_clear = 1'b1;
      tick();
      a_clear = 1'b0;
      ma[0] = 0; ma[1] = 0;
      checks++; if (a_out_valid !== 1'b1 || a_out_index !== 1'b1 || a_out_data !== 16'h0 || a_values !== 32'h0) begin
         errors++; $display("FAIL clrs_beat1: v%b i%h d%h vals%h want 1 1 0 0", a_out_valid, a_out_index, a_out_data, a_values);
      end
      tick();
      checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL clrs_done: got %b want 1", a_done); end
      tick();
      a_out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int beat = 0;
      int cyc  = 0;
      bit attempted = 0;
      bit load_now;
      bit go;
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         v = 16'($urandom);
         if (i == 3) v = v | 16'h8000;
         b_load(1'b0, i, v);
         mb[i] = sx(v);
      end
      checks++; if (b_values !== pack_b()) begin errors++; $display("FAIL b2b_loaded: got %h want %h", b_values, pack_b()); end
      b_stream_start = 1'b1;
      tick();
      b_stream_start = 1'b0;
      while (beat < 4 && cyc < 100) begin
         checks++; if (b_out_valid !== 1'b1 || b_busy !== 1'b1 || b_out_index !== beat[1:0] ||
                       b_out_data !== 16'(mb[beat]) || b_out_last !== (beat == 3)) begin
            errors++; $display("FAIL b2b_beat%0d: v%b busy%b i%h d%h l%b want 1 1 %h %h %b", beat, b_out_valid, b_busy,
                               b_out_index, b_out_data, b_out_last, beat[1:0], 16'(mb[beat]), (beat == 3));
         end
         b_out_ready = cyc[0];
         load_now = 0;
         if (beat == 1 && !attempted) begin
            attempted      = 1;
            load_now       = 1;
            b_load_en      = 1'b1;
            b_load_mode    = 1'b0;
            b_load_address = 16'h0000;
            b_load_value   = 16'($urandom);
         end
         go = b_out_ready;
         tick();
         b_load_en = 1'b0;
         if (load_now) begin
            checks++; if (b_load_reject !== 1'b1 || b_values !== pack_b()) begin
               errors++; $display("FAIL b2b_busy_load: reject %b values %h want 1 %h", b_load_reject, b_values, pack_b());
            end
         end
         if (go) beat++;
         cyc++;
      end
      checks++; if (beat != 4) begin errors++; $display("FAIL b2b_timeout: beats %0d want 4", beat); end
      b_out_ready = 1'b0;
      checks++; if (b_out_valid !== 1'b0 || b_done !== 1'b1) begin
         errors++; $display("FAIL b2b_done: v%b done%b want 0 1", b_out_valid, b_done);
      end
      tick();
      checks++; if (b_done !== 1'b0 || b_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: done%b busy%b want 0 0", b_done, b_busy);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         b_load(1'b0, i, 16'($urandom) | 16'h0001);
      end
      b_out_ready    = 1'b1;
      b_stream_start = 1'b1;
      tick();
      b_stream_start = 1'b0;
      tick();
      checks++; if (b_out_index !== 2'd1) begin errors++; $display("FAIL rstmid_at_beat1: got %h want 1", b_out_index); end
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) mb[i] = 0;
      ma[0] = 0; ma[1] = 0;
      checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
         errors++; $display("FAIL rstmid_ctrl: v%b busy%b done%b want 0 0 0", b_out_valid, b_busy, b_done);
      end
      checks++; if (b_values !== pack_b() || b_out_index !== 2'd0) begin
         errors++; $display("FAIL rstmid_data: values %h i%h want %h 0", b_values, b_out_index, pack_b());
      end
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (b_done !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_done: done%b v%b want 0 0", b_done, b_out_valid);
         end
      end
      b_out_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      a_clear = 0; a_load_en = 0; a_load_mode = 0; a_load_address = '0; a_load_value = '0;
      a_stream_start = 0; a_out_ready = 0;
      b_clear = 0; b_load_en = 0; b_load_mode = 0; b_load_address = '0; b_load_value = '0;
      b_stream_start = 0; b_out_ready = 0;
      for (int i = 0; i < 2; i++) ma[i] = 0;
      for (int i = 0; i < 4; i++) mb[i] = 0;

      test_reset();
      test_overwrite();
      test_accumulate();
      test_reject_clear();
      test_stream_relu();
      test_clear_stream();
      test_back_to_back();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/neuron_layer_stream.md
Name: neuron_layer_stream

Overview:
- Parametrised successor of the two-entry neuron value register bank in the fully-connected datapath.
- Holds NUM_NEURONS signed neuron values, loaded by address, with two load modes: overwrite and saturating accumulate.
- Streams the stored values, with optional ReLU, to the next FC stage over a valid/ready handshake.
- Sits between the MAC array / load bus and the next layer's input loader.

Parameters:
- DATA_WIDTH, 16, width of each neuron value (signed two's complement).
- NUM_NEURONS, 2, number of neuron registers (>=1).
- ADDR_WIDTH, 16, width of load_address.
- RELU_EN, 1, 1 = streamed output passes through ReLU; 0 = raw values.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all neuron registers.
- load_en  in  1  load strobe.
- load_mode  in  1  0 = overwrite; 1 = saturating accumulate.
- load_address  in  ADDR_WIDTH  target neuron index.
- load_value  in  DATA_WIDTH  signed load operand.
- load_reject  out  1  one-cycle pulse: load ignored (out of range or busy).
- values  out  NUM_NEURONS*DATA_WIDTH  raw register contents, neuron i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- stream_start  in  1  request to stream all neurons.
- busy  out  1  high while in STREAM or DONE.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_WIDTH  streamed value (ReLU applied if RELU_EN).
- out_index  out  clog2(NUM_NEURONS) (min 1)  index of current beat.
- out_last  out  1  current beat is index NUM_NEURONS-1.
- done  out  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Reset (reset=0, async):
  - All registers = 0; FSM = IDLE.
  - Outputs: out_valid = 0, out_index = 0, done = 0, load_reject = 0, busy = 0.
- Registers update on the clk edge; values reflects an update on the cycle after the load.
- Load priority: clear > load > hold. clear with load_en in the same cycle: all registers = 0, load dropped, no reject.
- Load acceptance: load_en=1, FSM=IDLE and load_address < NUM_NEURONS.
  - Otherwise, when load_en=1 and clear=0: load_reject=1 for one cycle, no register changes.
- Overwrite: reg[addr] <= load_value.
- Accumulate: reg[addr] <= sat(reg[addr] + load_value).
  - Sum computed at DATA_WIDTH+1 bits.
  - Clamps to max (2^(DATA_WIDTH-1)-1) on positive overflow and to min (-2^(DATA_WIDTH-1)) on negative overflow.
- FSM IDLE -> STREAM on stream_start=1; stream_start ignored in other states.
  - Cycle after start: out_valid=1, out_index=0.
- STREAM:
  - out_data = RELU_EN ? max(reg[out_index], 0) : reg[out_index].
  - out_data is a combinational read of the current register; registers cannot change during STREAM.
  - Transfer occurs when out_valid & out_ready.
  - On transfer with out_last=0: out_index increments next cycle, out_valid stays 1.
  - With out_ready=0: out_valid, out_index and out_data are held stable.
  - On transfer with out_last=1: -> DONE, out_valid=0.
- DONE: done=1 for exactly one cycle -> IDLE, out_index = 0. busy=1 in DONE.
- clear during STREAM: registers zeroed, stream continues and emits zeros for remaining beats.
- Reset mid-stream: immediate abort to IDLE, all zeros, no done pulse.
- NUM_NEURONS=1: the single beat has out_last=1.

Test Plan:
- Reset, then overwrite 0x0005 to addr 0 and 0xFFF0 to addr 1 -> values = {0xFFF0, 0x0005} one cycle later; load_reject stays 0.
- Accumulate 0x7FF0 + 0x0020 into addr 0 -> 0x7FFF (saturated); 0x8010 + 0xFFE0 -> 0x8000.
- Load to addr 2 (NUM_NEURONS=2) -> load_reject pulse, values unchanged; clear with load_en same cycle -> all zero, no reject.
- Stream with RELU_EN=1, regs {0xFFF0, 0x0005}, out_ready=1 -> beats (idx0, 0x0005), (idx1, 0x0000, last=1); done pulse next cycle; busy then low.
- Stream with out_ready toggling 0/1 and a load attempted mid-stream -> data and index held while stalled; the load rejected; NUM_NEURONS=4 build emits 4 beats in order.
- Assert reset during beat 1 of a 4-neuron stream -> out_valid=0, busy=0, values=0 immediately; no done pulse.
